// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: shares one memory port between instruction fetch and
// data load/store, with round-robin tie-break and a one-cycle completion pulse.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read,
    input  logic [31:0] instr_address,
    output logic [31:0] instr_readdata,
    output logic        instr_ready,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_address,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  data_byteenable,
    output logic [31:0] data_readdata,
    output logic        data_ready,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest
);

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned BW = 4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        INSTR_ACC = 2'd1,
        DATA_ACC  = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t state;
    logic   last_grant;      // 1 = data port was granted most recently
    logic   data_req_c;
    logic   grant_instr_c;

    // Instruction wins unless data also requests and instruction went last
    always_comb begin
        data_req_c    = data_read | data_write;
        grant_instr_c = instr_read & (~data_req_c | last_grant);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            instr_readdata <= DW'(0);
            instr_ready    <= 1'b0;
            data_readdata  <= DW'(0);
            data_ready     <= 1'b0;
            mem_address    <= AW'(0);
            mem_read       <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= DW'(0);
            mem_byteenable <= BW'(0);
        end else begin
            instr_ready <= 1'b0;
            data_ready  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_instr_c) begin
                        state          <= INSTR_ACC;
                        mem_address    <= instr_address;
                        mem_byteenable <= {BW{1'b1}};
                        mem_read       <= 1'b1;
                        mem_write      <= 1'b0;
                    end else if (data_req_c) begin
                        // A simultaneous read+write request is serviced as a store
                        state          <= DATA_ACC;
                        mem_address    <= data_address;
                        mem_writedata  <= data_writedata;
                        mem_byteenable <= data_byteenable;
                        mem_write      <= data_write;
                        mem_read       <= ~data_write;
                    end
                end
                INSTR_ACC: begin
                    if (!mem_waitrequest) begin
                        instr_readdata <= mem_readdata;
                        instr_ready    <= 1'b1;
                        mem_read       <= 1'b0;
                        last_grant     <= 1'b0;
                        state          <= RESP;
                    end
                end
                DATA_ACC: begin
                    if (!mem_waitrequest) begin
                        if (mem_read) begin
                            data_readdata <= mem_readdata;
                        end
                        data_ready <= 1'b1;
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        last_grant <= 1'b1;
                        state      <= RESP;
                    end
                end
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: vector table of single-port
// transactions plus hand sequences for contention and mid-access reset.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_read;
    logic [31:0] instr_address;
    logic [31:0] instr_readdata;
    logic        instr_ready;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_address;
    logic [31:0] data_writedata;
    logic [3:0]  data_byteenable;
    logic [31:0] data_readdata;
    logic        data_ready;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;

    mem_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .instr_read      (instr_read),
        .instr_address   (instr_address),
        .instr_readdata  (instr_readdata),
        .instr_ready     (instr_ready),
        .data_read       (data_read),
        .data_write      (data_write),
        .data_address    (data_address),
        .data_writedata  (data_writedata),
        .data_byteenable (data_byteenable),
        .data_readdata   (data_readdata),
        .data_ready      (data_ready),
        .mem_address     (mem_address),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_writedata   (mem_writedata),
        .mem_byteenable  (mem_byteenable),
        .mem_readdata    (mem_readdata),
        .mem_waitrequest (mem_waitrequest)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_data;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
        int          waits;
        logic        drop;
        logic        exp_read;
        logic        exp_write;
        logic [3:0]  exp_be;
    } vec_t;

    localparam int NVEC = 6;
    vec_t vecs [NVEC];

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_ird = 32'h0;
    logic [31:0] exp_drd = 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        instr_read      = 1'b0;
        instr_address   = 32'h0;
        data_read       = 1'b0;
        data_write      = 1'b0;
        data_address    = 32'h0;
        data_writedata  = 32'h0;
        data_byteenable = 4'h0;
        mem_readdata    = 32'h0;
        mem_waitrequest = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        exp_ird = 32'h0;
        exp_drd = 32'h0;
    endtask

    task automatic run_vec(input vec_t v);
        @(negedge clk);
        if (v.is_data) begin
            data_read       = v.rd;
            data_write      = v.wr;
            data_address    = v.addr;
            data_writedata  = v.wdata;
            data_byteenable = v.be;
        end else begin
            instr_read      = 1'b1;
            instr_address   = v.addr;
            data_byteenable = 4'b0101;
        end
        mem_waitrequest = 1'b1;
        mem_readdata    = ~v.rdata;
        for (int s = 1; s <= v.waits + 1; s++) begin
            @(negedge clk);
            chk("strobe_read", 32'(mem_read), 32'(v.exp_read));
            chk("strobe_write", 32'(mem_write), 32'(v.exp_write));
            chk("strobe_addr", mem_address, v.addr);
            chk("strobe_be", 32'(mem_byteenable), 32'(v.exp_be));
            if (v.exp_write) chk("strobe_wdata", mem_writedata, v.wdata);
            chk("ready_during_acc", 32'({instr_ready, data_ready}), 32'h0);
            mem_waitrequest = (s <= v.waits);
            mem_readdata    = (s <= v.waits) ? ~v.rdata : v.rdata;
            if (s == 1) begin
                instr_address   = ~v.addr;
                data_address    = ~v.addr;
                data_writedata  = ~v.wdata;
                data_byteenable = ~v.be;
                if (v.drop) begin
                    instr_read = 1'b0;
                    data_read  = 1'b0;
                    data_write = 1'b0;
                end
            end
        end
        if (!v.is_data) exp_ird = v.rdata;
        else if (v.rd && !v.wr) exp_drd = v.rdata;
        @(negedge clk);
        chk("resp_instr_ready", 32'(instr_ready), 32'(!v.is_data));
        chk("resp_data_ready", 32'(data_ready), 32'(v.is_data));
        chk("resp_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("resp_instr_rdata", instr_readdata, exp_ird);
        chk("resp_data_rdata", data_readdata, exp_drd);
        idle_inputs();
        @(negedge clk);
        chk("idle_ready", 32'({instr_ready, data_ready}), 32'h0);
        chk("idle_addr_hold", mem_address, v.addr);
        chk("idle_instr_rdata", instr_readdata, exp_ird);
        chk("idle_data_rdata", data_readdata, exp_drd);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          data  rd    wr    addr          wdata         be       rdata         w  drop  erd   ewr   ebe
        vecs[0] = '{1'b0, 1'b0, 1'b0, 32'hBFC00000, 32'h0,        4'h0,    32'h3C010001, 0, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h00001000, 32'hDEADBEEF, 4'b0011, 32'h55555555, 3, 1'b0, 1'b0, 1'b1, 4'b0011};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h00002004, 32'h0,        4'b1111, 32'h12345678, 1, 1'b0, 1'b1, 1'b0, 4'b1111};
        vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h00003000, 32'hCAFEF00D, 4'b1100, 32'h77777777, 0, 1'b0, 1'b0, 1'b1, 4'b1100};
        vecs[4] = '{1'b0, 1'b0, 1'b0, 32'h00400010, 32'h0,        4'h0,    32'h8C420004, 2, 1'b1, 1'b1, 1'b0, 4'b1111};
        vecs[5] = '{1'b1, 1'b1, 1'b0, 32'h00000005, 32'h0,        4'b0001, 32'h000000AA, 0, 1'b1, 1'b1, 1'b0, 4'b0001};

        idle_inputs();
        reset = 1'b0;
        do_reset();
        chk("reset_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("reset_ready", 32'({instr_ready, data_ready}), 32'h0);
        chk("reset_addr", mem_address, 32'h0);
        chk("reset_wdata", mem_writedata, 32'h0);
        chk("reset_be", 32'(mem_byteenable), 32'h0);
        chk("reset_rdata", instr_readdata | data_readdata, 32'h0);

        for (int i = 0; i < NVEC; i++) run_vec(vecs[i]);

        // Sustained contention after reset: instruction first, then alternate
        do_reset();
        @(negedge clk);
        instr_read      = 1'b1;
        instr_address   = 32'h000000A0;
        data_read       = 1'b1;
        data_address    = 32'h000000D0;
        data_byteenable = 4'b1111;
        mem_waitrequest = 1'b0;
        mem_readdata    = 32'h00000011;
        for (int g = 0; g < 4; g++) begin
            logic found;
            found = 1'b0;
            for (int c = 0; c < 8 && !found; c++) begin
                @(negedge clk);
                if (mem_read) found = 1'b1;
            end
            if (!found) begin
                tests++;
                fails++;
                $display("FAIL rr_timeout: no grant %0d within 8 cycles", g);
            end else begin
                chk("rr_grant_addr", mem_address, (g % 2 == 0) ? 32'h000000A0 : 32'h000000D0);
            end
        end
        instr_read = 1'b0;
        data_read  = 1'b0;
        @(negedge clk);
        chk("rr_last_data_ready", 32'({instr_ready, data_ready}), 32'h1);
        chk("rr_data_rdata", data_readdata, 32'h00000011);
        @(negedge clk);

        // Reset during a stalled store abandons it
        data_write      = 1'b1;
        data_address    = 32'h00001000;
        data_writedata  = 32'hDEADBEEF;
        data_byteenable = 4'b0011;
        mem_waitrequest = 1'b1;
        @(negedge clk);
        chk("mid_rst_write_active", 32'(mem_write), 32'h1);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_strobes", 32'({mem_read, mem_write}), 32'h0);
        chk("mid_rst_ready", 32'({instr_ready, data_ready}), 32'h0);
        chk("mid_rst_addr", mem_address, 32'h0);
        chk("mid_rst_wdata", mem_writedata, 32'h0);
        chk("mid_rst_be", 32'(mem_byteenable), 32'h0);
        chk("mid_rst_instr_rdata", instr_readdata, 32'h0);
        chk("mid_rst_data_rdata", data_readdata, 32'h0);
        reset = 1'b1;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_no_ready", 32'({instr_ready, data_ready, mem_read, mem_write}), 32'h0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
